// File: rtl/upsample_module.sv
// 2x nearest-neighbour upsampler: receives one pooled row (or a whole 2x2 channel at flen=4),
// then emits it twice with every pixel doubled horizontally.
module upsample_module #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [3:0]                        S_AXIS_TKEEP,
    input  logic                              S_AXIS_TUSER,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TUSER,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                        M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID,
    input  logic                              up_start,
    output logic                              up_done,
    input  logic [5:0]                        flen,
    input  logic [8:0]                        in_channel
);

    typedef enum logic [1:0] {StIdle, StRecv, StSend, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  flen_q, flen_d;
    logic [8:0]  nch_q, nch_d;
    logic [8:0]  ch_q, ch_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  ocnt_q, ocnt_d;
    logic [1:0]  rcnt_q, rcnt_d;
    logic [7:0]  row_buf_q [16];
    logic [7:0]  row_buf_d [16];
    logic        tready_q, tready_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        done_q, done_d;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;

    logic        legal_cfg, is4;
    logic [3:0]  glast, nrlast, sel_idx;
    logic [1:0]  rlast;
    logic [2:0]  pmask, k;
    logic [7:0]  b_lo, b_hi;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] word_data;
    logic        word_last;
    logic        unused_inputs;

    assign unused_inputs = ^{S_AXIS_TKEEP, S_AXIS_TUSER, S_AXIS_TLAST};

    assign legal_cfg = (flen == 6'd4 || flen == 6'd8 || flen == 6'd16 || flen == 6'd32) &&
                       (in_channel != 9'd0);
    assign is4 = (flen_q == 6'd4);

    // Per-size terminal counts: words per group, rows per channel, words per row, pass mask.
    always_comb begin
        glast  = 4'd3;
        nrlast = 4'd0;
        rlast  = 2'd0;
        pmask  = 3'd0;
        case (flen_q)
            6'd8:    begin glast = 4'd3;  nrlast = 4'd3;  rlast = 2'd0; pmask = 3'd1; end
            6'd16:   begin glast = 4'd7;  nrlast = 4'd7;  rlast = 2'd1; pmask = 3'd3; end
            6'd32:   begin glast = 4'd15; nrlast = 4'd15; rlast = 2'd3; pmask = 3'd7; end
            default: ;
        endcase
    end

    // Index of the word being loaded into the output register this cycle.
    assign sel_idx   = tvalid_q ? (ocnt_q + 4'd1) : ocnt_q;
    assign k         = is4 ? {2'b00, sel_idx[1]} : (sel_idx[2:0] & pmask);
    assign b_lo      = row_buf_q[{k, 1'b0}];
    assign b_hi      = row_buf_q[{k, 1'b1}];
    assign word_data = {b_hi, b_hi, b_lo, b_lo};
    assign word_last = (sel_idx == glast) && (row_q == nrlast) && (ch_q == nch_q - 9'd1);

    always_comb begin
        state_d   = state_q;
        flen_d    = flen_q;
        nch_d     = nch_q;
        ch_d      = ch_q;
        row_d     = row_q;
        ocnt_d    = ocnt_q;
        rcnt_d    = rcnt_q;
        row_buf_d = row_buf_q;
        tready_d  = tready_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        done_d    = done_q;
        unique case (state_q)
            StIdle: begin
                if (up_start) begin
                    flen_d = flen;
                    nch_d  = in_channel;
                    ch_d   = 9'd0;
                    row_d  = 4'd0;
                    ocnt_d = 4'd0;
                    rcnt_d = 2'd0;
                    if (legal_cfg) begin
                        state_d  = StRecv;
                        tready_d = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StRecv: begin
                if (S_AXIS_TVALID && tready_q) begin
                    for (int j = 0; j < 4; j++) begin
                        row_buf_d[{rcnt_q, 2'b00} + 4'(j)] = S_AXIS_TDATA[8*j +: 8];
                    end
                    if (rcnt_q == rlast) begin
                        tready_d = 1'b0;
                        ocnt_d   = 4'd0;
                        state_d  = StSend;
                    end else begin
                        rcnt_d = rcnt_q + 2'd1;
                    end
                end
            end
            StSend: begin
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = word_data;
                    tlast_d  = word_last;
                end else if (M_AXIS_TREADY) begin
                    if (ocnt_q == glast) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        ocnt_d   = 4'd0;
                        rcnt_d   = 2'd0;
                        if (row_q != nrlast) begin
                            row_d    = row_q + 4'd1;
                            tready_d = 1'b1;
                            state_d  = StRecv;
                        end else if (ch_q != nch_q - 9'd1) begin
                            row_d    = 4'd0;
                            ch_d     = ch_q + 9'd1;
                            tready_d = 1'b1;
                            state_d  = StRecv;
                        end else begin
                            row_d   = 4'd0;
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end else begin
                        ocnt_d  = ocnt_q + 4'd1;
                        tdata_d = word_data;
                        tlast_d = word_last;
                    end
                end
            end
            StDone: begin
                if (!up_start) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            flen_q   <= 6'd0;
            nch_q    <= 9'd0;
            ch_q     <= 9'd0;
            row_q    <= 4'd0;
            ocnt_q   <= 4'd0;
            rcnt_q   <= 2'd0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < 16; i++) row_buf_q[i] <= 8'd0;
        end else begin
            state_q  <= state_d;
            flen_q   <= flen_d;
            nch_q    <= nch_d;
            ch_q     <= ch_d;
            row_q    <= row_d;
            ocnt_q   <= ocnt_d;
            rcnt_q   <= rcnt_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            done_q   <= done_d;
            for (int i = 0; i < 16; i++) row_buf_q[i] <= row_buf_d[i];
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TKEEP  = 4'hF;
    assign M_AXIS_TUSER  = 1'b0;
    assign up_done       = done_q;

endmodule

// File: tb/tb_upsample_module.sv
// Directed bench for upsample_module: flen=4 vector table plus streamed runs against a
// raster-order reference model of nearest-neighbour upsampling.
module tb_upsample_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TKEEP;
    logic        S_AXIS_TUSER;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TUSER;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        up_start;
    logic        up_done;
    logic [5:0]  flen;
    logic [8:0]  in_channel;

    int checks   = 0;
    int failures = 0;
    logic [31:0] first_w [4];

    always #5 clk = ~clk;

    upsample_module #(.C_S00_AXIS_TDATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .up_start      (up_start),
        .up_done       (up_done),
        .flen          (flen),
        .in_channel    (in_channel)
    );

    typedef struct packed {
        logic [31:0]      din;
        logic [3:0][31:0] e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] din, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] e3);
        vec_t v;
        v.din  = din;
        v.e[0] = e0;
        v.e[1] = e1;
        v.e[2] = e2;
        v.e[3] = e3;
        return v;
    endfunction

    // Input pixel i (raster order) of channel c: incrementing bytes across the run.
    function automatic logic [7:0] pix(input int fl, input int c, input int i);
        int h = fl / 2;
        return 8'((c * h * h + i + 1) & 255);
    endfunction

    function automatic logic [31:0] in_word(input int fl, input int c, input int n);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = pix(fl, c, 4 * n + j);
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int fl, input int c, input int w);
        logic [31:0] r;
        int p, y, x;
        for (int j = 0; j < 4; j++) begin
            p = 4 * w + j;
            y = p / fl;
            x = p % fl;
            r[8*j +: 8] = pix(fl, c, (y / 2) * (fl / 2) + x / 2);
        end
        return r;
    endfunction

    task automatic run(input int fl, input int nch, input bit gap, input bit rnd,
                       input int abort_at, input bit drop_start);
        int in_per    = (fl == 4) ? 1 : fl * fl / 16;
        int out_per   = fl * fl / 4;
        int total_in  = in_per * nch;
        int total_out = out_per * nch;
        int icount = 0, ocount = 0, gapc = 0, cyc = 0;
        bit stall = 0, overlap = 0, aborted = 0, seen = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        @(negedge clk);
        flen       = 6'(fl);
        in_channel = 9'(nch);
        up_start   = 1'b1;
        while (ocount < total_out && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (drop_start && cyc == 3) up_start = 1'b0;
            if (S_AXIS_TREADY && M_AXIS_TVALID) overlap = 1;
            if (gapc > 0) begin
                gapc--;
                S_AXIS_TVALID = 1'b0;
            end else if (icount < total_in) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = in_word(fl, icount / in_per, icount % in_per);
                if (S_AXIS_TREADY) begin
                    icount++;
                    if (gap) gapc = 3;
                end
            end else begin
                S_AXIS_TVALID = 1'b0;
            end
            M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (M_AXIS_TVALID) begin
                if (stall) begin
                    chk("hold_data", M_AXIS_TDATA, prev_data);
                    chk("hold_last", 32'(M_AXIS_TLAST), 32'(prev_last));
                end
                if (M_AXIS_TREADY) begin
                    chk($sformatf("data_f%0d[%0d]", fl, ocount), M_AXIS_TDATA,
                        exp_word(fl, ocount / out_per, ocount % out_per));
                    chk($sformatf("last_f%0d[%0d]", fl, ocount), 32'(M_AXIS_TLAST),
                        32'(ocount == total_out - 1));
                    if (ocount < 4) first_w[ocount] = M_AXIS_TDATA;
                    ocount++;
                end
                stall     = !M_AXIS_TREADY;
                prev_data = M_AXIS_TDATA;
                prev_last = M_AXIS_TLAST;
            end else begin
                stall = 0;
            end
            if (abort_at >= 0 && ocount == abort_at) begin
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            rst           = 1'b1;
            up_start      = 1'b0;
            S_AXIS_TVALID = 1'b0;
            M_AXIS_TREADY = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_tready", 32'(S_AXIS_TREADY), 32'd0);
            chk("abort_tvalid", 32'(M_AXIS_TVALID), 32'd0);
            chk("abort_tlast",  32'(M_AXIS_TLAST),  32'd0);
            chk("abort_tdata",  M_AXIS_TDATA,       32'd0);
            chk("abort_done",   32'(up_done),       32'd0);
            @(negedge clk);
            chk("abort_idle", 32'(S_AXIS_TREADY | M_AXIS_TVALID | up_done), 32'd0);
            return;
        end
        S_AXIS_TVALID = 1'b0;
        chk("out_count", 32'(ocount), 32'(total_out));
        chk("in_count",  32'(icount), 32'(total_in));
        chk("no_overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (up_done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("tvalid_end", 32'(M_AXIS_TVALID), 32'd0);
        if (drop_start) begin
            @(negedge clk);
            chk("done_fallthrough", 32'(up_done), 32'd0);
        end else begin
            repeat (3) @(negedge clk);
            chk("done_hold", 32'(up_done), 32'd1);
            up_start = 1'b0;
            @(negedge clk);
            chk("done_clear", 32'(up_done), 32'd0);
        end
    endtask

    task automatic bad_cfg(input int fl, input int nch);
        bit act = 0, seen = 0;
        @(negedge clk);
        flen       = 6'(fl);
        in_channel = 9'(nch);
        up_start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (S_AXIS_TREADY || M_AXIS_TVALID) act = 1;
            if (up_done) seen = 1;
        end
        chk($sformatf("bad_cfg_done_f%0d_c%0d", fl, nch), 32'(seen), 32'd1);
        chk($sformatf("bad_cfg_quiet_f%0d_c%0d", fl, nch), 32'(act), 32'd0);
        up_start = 1'b0;
        @(negedge clk);
        chk("bad_cfg_clear", 32'(up_done), 32'd0);
        @(negedge clk);
        chk("bad_cfg_idle", 32'(S_AXIS_TREADY | up_done), 32'd0);
    endtask

    initial begin
        vec_t tbl [4];
        int   n;
        tbl[0] = mk(32'h44332211, 32'h22221111, 32'h22221111, 32'h44443333, 32'h44443333);
        tbl[1] = mk(32'hDDCCBBAA, 32'hBBBBAAAA, 32'hBBBBAAAA, 32'hDDDDCCCC, 32'hDDDDCCCC);
        tbl[2] = mk(32'h00FF00FF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
        tbl[3] = mk(32'h80017F00, 32'h7F7F0000, 32'h7F7F0000, 32'h80800101, 32'h80800101);

        rst           = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = 4'hF;
        S_AXIS_TUSER  = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b0;
        up_start      = 1'b0;
        flen          = 6'd4;
        in_channel    = 9'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tready", 32'(S_AXIS_TREADY), 32'd0);
        chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rst_tlast",  32'(M_AXIS_TLAST),  32'd0);
        chk("rst_tdata",  M_AXIS_TDATA,       32'd0);
        chk("rst_done",   32'(up_done),       32'd0);
        chk("tkeep",      32'(M_AXIS_TKEEP),  32'hF);
        chk("tuser",      32'(M_AXIS_TUSER),  32'd0);

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            flen          = 6'd4;
            in_channel    = 9'd1;
            up_start      = 1'b1;
            M_AXIS_TREADY = 1'b1;
            for (int t = 0; t < 10 && !S_AXIS_TREADY; t++) @(negedge clk);
            chk("f4_tready", 32'(S_AXIS_TREADY), 32'd1);
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = tbl[v].din;
            @(negedge clk);
            S_AXIS_TVALID = 1'b0;
            chk("f4_tready_drop", 32'(S_AXIS_TREADY), 32'd0);
            n = 0;
            for (int t = 0; t < 20 && n < 4; t++) begin
                @(negedge clk);
                if (M_AXIS_TVALID) begin
                    chk($sformatf("f4_vec%0d_w%0d", v, n), M_AXIS_TDATA, tbl[v].e[n]);
                    chk($sformatf("f4_vec%0d_last%0d", v, n), 32'(M_AXIS_TLAST), 32'(n == 3));
                    n++;
                end
            end
            chk("f4_count", 32'(n), 32'd4);
            @(negedge clk);
            chk("f4_done", 32'(up_done), 32'd1);
            up_start = 1'b0;
            @(negedge clk);
            chk("f4_done_clear", 32'(up_done), 32'd0);
        end

        run(8, 2, 1'b0, 1'b0, -1, 1'b0);
        chk("f8_first0", first_w[0], 32'h02020101);
        chk("f8_first1", first_w[1], 32'h04040303);
        chk("f8_first2", first_w[2], 32'h02020101);
        chk("f8_first3", first_w[3], 32'h04040303);

        run(32, 3, 1'b0, 1'b1, -1, 1'b0);
        run(16, 2, 1'b0, 1'b0, -1, 1'b0);
        run(16, 2, 1'b1, 1'b0, -1, 1'b0);
        run(8, 1, 1'b0, 1'b0, 5, 1'b0);
        run(8, 1, 1'b0, 1'b0, -1, 1'b0);
        run(8, 2, 1'b0, 1'b1, -1, 1'b1);
        bad_cfg(12, 1);
        bad_cfg(8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
